dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter_rr_arb2.sv | 27 ++
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - state_t  : arbiter FSM encoding (IDLE / ACCESS / RESP)
//   - req_id_t : requester identity (CPU=0, DBG=1)
//   - ADDR_W_DEF / DATA_W_DEF : default address and data widths
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's command/response bundle.
//   req/we/addr/wdata : command, driven by the requester (master)
//   gnt               : command accepted (one cycle)
//   done/rdata/err    : completion pulse, read data, rejection flag
//
// Handshake: a requester raises req with a stable command and holds both
// until it sees gnt=1 on a clock edge; after that it may drop req or
// present a new command. done arrives exactly one cycle after gnt, and
// rdata is only meaningful (and only changes) on a done cycle.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = dmem_arb_pkg::DATA_W_DEF
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, done, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, done, rdata, err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick.
//   req0_i / req1_i : CPU / DBG request
//   last_i          : requester served most recently
//   winner_o        : chosen requester (don't-care when valid_o=0)
//   valid_o         : at least one request present
// A lone requester always wins; on a tie the one not served last wins.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic    req0_i,
  input  logic    req1_i,
  input  req_id_t last_i,
  output req_id_t winner_o,
  output logic    valid_o
);

  always_comb begin
    valid_o  = req0_i | req1_i;
    winner_o = REQ_CPU;
    if (req0_i && req1_i) begin
      winner_o = (last_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else if (req1_i) begin
      winner_o = REQ_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a CPU and a
// debug requester. Each access takes ACCESS (grant + memory strobe) then
// RESP (done + read data); RESP may chain straight into the next ACCESS.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   cpu, dbg            : requester bundles (dmem_arbiter_if.slave)
//   MemRead, MemWrite   : one-cycle memory strobes (never both high)
//   mem_addr, mem_wdata : latched command towards memory
//   mem_rdata           : combinational read data from memory
//   state_o             : current FSM state, for observation
//
// Build option: DMEM_ARB_ALIGN_CHECK_EN rejects commands whose address is
// not word aligned (no memory strobe, done+err in RESP, rdata kept).
// Without it err is always 0 and memory ignores addr[1:0].
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dbg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output state_t            state_o
);

  state_t            state_q;
  req_id_t           last_q;
  req_id_t           owner_q;
  logic              we_q;
  logic              misalign_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata_q [2];
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  req_id_t           arb_winner;
  logic              arb_valid;
  logic              cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_d;
  logic              misalign_d;

  rr_arb2 u_rr_arb2 (
    .req0_i   (cpu.req),
    .req1_i   (dbg.req),
    .last_i   (last_q),
    .winner_o (arb_winner),
    .valid_o  (arb_valid)
  );

  // Command of whichever requester the arbiter picked this cycle.
  always_comb begin
    cmd_we_d    = cpu.we;
    cmd_addr_d  = cpu.addr;
    cmd_wdata_d = cpu.wdata;
    if (arb_winner == REQ_DBG) begin
      cmd_we_d    = dbg.we;
      cmd_addr_d  = dbg.addr;
      cmd_wdata_d = dbg.wdata;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign misalign_d = (cmd_addr_d[1:0] != 2'b00);
`else
  assign misalign_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= REQ_DBG;
      owner_q     <= REQ_CPU;
      we_q        <= 1'b0;
      misalign_q  <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Pulses default low; each is raised for exactly one state.
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (arb_valid) begin
            state_q             <= ACCESS;
            owner_q             <= arb_winner;
            last_q              <= arb_winner;
            we_q                <= cmd_we_d;
            misalign_q          <= misalign_d;
            gnt_q[arb_winner]   <= 1'b1;
            mem_rd_q            <= !cmd_we_d && !misalign_d;
            mem_wr_q            <= cmd_we_d && !misalign_d;
            mem_addr_q          <= cmd_addr_d;
            mem_wdata_q         <= cmd_wdata_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // Requests are not looked at here; a held req is picked up in RESP.
          state_q         <= RESP;
          done_q[owner_q] <= 1'b1;
          if (misalign_q) begin
            err_q[owner_q] <= 1'b1;
          end else begin
            rdata_q[owner_q] <= we_q ? '0 : mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu.gnt   = gnt_q[REQ_CPU];
  assign cpu.done  = done_q[REQ_CPU];
  assign cpu.err   = err_q[REQ_CPU];
  assign cpu.rdata = rdata_q[0];
  assign dbg.gnt   = gnt_q[REQ_DBG];
  assign dbg.done  = done_q[REQ_DBG];
  assign dbg.err   = err_q[REQ_DBG];
  assign dbg.rdata = rdata_q[1];

  assign MemRead   = mem_rd_q;
  assign MemWrite  = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a word-addressed
// memory model behind the arbiter. Honours DMEM_ARB_ALIGN_CHECK_EN.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int GW = 2 + 2 + AW + DW;
  localparam int RW = 2 + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_bus ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dbg_bus ();

  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  state_t        state;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu       (cpu_bus),
    .dbg       (dbg_bus),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_o   (state)
  );

  // Memory: word i = 0xA5000000|i, except word 4 = 0xDEADBEEF; reloaded on reset.
  logic [DW-1:0] mem [128];
  assign mem_rdata = mem[mem_addr[AW-1:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= (i == 4) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
    end else if (MemWrite) begin
      mem[mem_addr[AW-1:2]] <= mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [GW-1:0] exp_gnt_q[$];
  logic [RW-1:0] exp_q[$];
  int gnt_cyc_q[$];
  int gnt_at[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [GW-1:0] gv(input int id, input logic rd, input logic wr,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {(id == 1), (id == 0), rd, wr, a, d};
  endfunction

  function automatic logic [RW-1:0] rv(input int id, input logic err, input logic [DW-1:0] d);
    return {(id == 1), (id == 0), err, d};
  endfunction

  // Monitor: pops an expectation whenever a grant/strobe or done is visible.
  always @(negedge clk) begin : monitor
    logic [GW-1:0] ag;
    logic [RW-1:0] ar;
    int id;
    if (cpu_bus.gnt === 1'b1 || dbg_bus.gnt === 1'b1 || MemRead === 1'b1 || MemWrite === 1'b1) begin
      ag = {dbg_bus.gnt, cpu_bus.gnt, MemRead, MemWrite, mem_addr, mem_wdata};
      if (exp_gnt_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant: got %0h want none", ag);
      end else begin
        check("grant", 64'(ag), 64'(exp_gnt_q.pop_front()));
      end
      gnt_cyc_q.push_back(cyc);
      if (cpu_bus.gnt === 1'b1) gnt_at[0] = cyc;
      if (dbg_bus.gnt === 1'b1) gnt_at[1] = cyc;
    end
    if (cpu_bus.done === 1'b1 || dbg_bus.done === 1'b1) begin
      ar = {dbg_bus.done, cpu_bus.done,
            (dbg_bus.done ? dbg_bus.err : cpu_bus.err),
            (dbg_bus.done ? dbg_bus.rdata : cpu_bus.rdata)};
      id = (dbg_bus.done === 1'b1) ? 1 : 0;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got %0h want none", ar);
      end else begin
        check("response", 64'(ar), 64'(exp_q.pop_front()));
      end
      check("gnt_to_done", 64'(cyc - gnt_at[id]), 64'd1);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int id, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      cpu_bus.req = req; cpu_bus.we = we; cpu_bus.addr = a; cpu_bus.wdata = d;
    end else begin
      dbg_bus.req = req; dbg_bus.we = we; dbg_bus.addr = a; dbg_bus.wdata = d;
    end
  endtask

  // Holds the command until granted; returns the number of edges waited.
  task automatic issue(input int id, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int waited);
    logic got;
    got = 1'b0;
    waited = 0;
    drive(id, 1'b1, we, a, d);
    while (!got && waited < 40) begin
      @(posedge clk); #1;
      waited++;
      got = (id == 0) ? cpu_bus.gnt : dbg_bus.gnt;
    end
    drive(id, 1'b0, 1'b0, '0, '0);
    if (!got) begin
      total++; bad++;
      $display("FAIL grant_timeout: id=%0d got no grant want grant within 40 cycles", id);
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_gnt_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL settle_timeout: got %0d pending want 0", exp_q.size() + exp_gnt_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  int w0, w1;

  initial begin
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_state",  64'(state), 64'(IDLE));
    check("rst_gnt",    64'({cpu_bus.gnt, dbg_bus.gnt}), 64'd0);
    check("rst_done",   64'({cpu_bus.done, dbg_bus.done}), 64'd0);
    check("rst_err",    64'({cpu_bus.err, dbg_bus.err}), 64'd0);
    check("rst_rdata",  64'({cpu_bus.rdata, dbg_bus.rdata}), 64'd0);
    check("rst_strobe", 64'({MemRead, MemWrite}), 64'd0);
    check("rst_maddr",  64'(mem_addr), 64'd0);
    check("rst_mwdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;

    // Single CPU read of 0x010
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h010, '0));
    exp_q.push_back(rv(0, 1'b0, 32'hDEADBEEF));
    issue(0, 1'b0, 9'h010, '0, w0);
    check("req_to_gnt", 64'(w0), 64'd1);
    settle();

    // Simultaneous requests right after reset: CPU first, DBG next
    do_reset();
    gnt_cyc_q.delete();
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h014, '0));
    exp_gnt_q.push_back(gv(1, 1'b1, 1'b0, 9'h018, '0));
    exp_q.push_back(rv(0, 1'b0, 32'hA5000005));
    exp_q.push_back(rv(1, 1'b0, 32'hA5000006));
    fork
      issue(0, 1'b0, 9'h014, '0, w0);
      issue(1, 1'b0, 9'h018, '0, w1);
    join
    settle();
    check("tie_gnt_count", 64'(gnt_cyc_q.size()), 64'd2);
    if (gnt_cyc_q.size() == 2) check("tie_gnt_gap", 64'(gnt_cyc_q[1] - gnt_cyc_q[0]), 64'd2);

    // Both requesters held busy for 6 accesses: strict alternation
    gnt_cyc_q.delete();
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h000, '0));
    exp_gnt_q.push_back(gv(1, 1'b0, 1'b1, 9'h040, 32'h22222222));
    exp_gnt_q.push_back(gv(0, 1'b0, 1'b1, 9'h030, 32'h11111111));
    exp_gnt_q.push_back(gv(1, 1'b1, 1'b0, 9'h040, '0));
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h030, '0));
    exp_gnt_q.push_back(gv(1, 1'b1, 1'b0, 9'h004, '0));
    exp_q.push_back(rv(0, 1'b0, 32'hA5000000));
    exp_q.push_back(rv(1, 1'b0, 32'h0));
    exp_q.push_back(rv(0, 1'b0, 32'h0));
    exp_q.push_back(rv(1, 1'b0, 32'h22222222));
    exp_q.push_back(rv(0, 1'b0, 32'h11111111));
    exp_q.push_back(rv(1, 1'b0, 32'hA5000001));
    fork
      begin
        issue(0, 1'b0, 9'h000, '0, w0);
        issue(0, 1'b1, 9'h030, 32'h11111111, w0);
        issue(0, 1'b0, 9'h030, '0, w0);
      end
      begin
        issue(1, 1'b1, 9'h040, 32'h22222222, w1);
        issue(1, 1'b0, 9'h040, '0, w1);
        issue(1, 1'b0, 9'h004, '0, w1);
      end
    join
    settle();
    check("b2b_gnt_count", 64'(gnt_cyc_q.size()), 64'd6);
    for (int i = 1; i < gnt_cyc_q.size(); i++)
      check("b2b_gnt_gap", 64'(gnt_cyc_q[i] - gnt_cyc_q[i-1]), 64'd2);

    // DBG write then CPU read of the same word
    exp_gnt_q.push_back(gv(1, 1'b0, 1'b1, 9'h020, 32'h12345678));
    exp_q.push_back(rv(1, 1'b0, 32'h0));
    issue(1, 1'b1, 9'h020, 32'h12345678, w1);
    settle();
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h020, '0));
    exp_q.push_back(rv(0, 1'b0, 32'h12345678));
    issue(0, 1'b0, 9'h020, '0, w0);
    settle();
    repeat (3) @(posedge clk);
    #1;
    check("dbg_rdata_hold", 64'(dbg_bus.rdata), 64'h0);
    check("cpu_rdata_hold", 64'(cpu_bus.rdata), 64'h12345678);

    // Reset in the middle of a CPU read
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h010, '0));
    issue(0, 1'b0, 9'h010, '0, w0);
    check("abort_in_access", 64'(state), 64'(ACCESS));
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_state", 64'(state), 64'(IDLE));
    check("abort_memread", 64'(MemRead), 64'd0);
    check("abort_done", 64'(cpu_bus.done), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_rdata", 64'(cpu_bus.rdata), 64'h0);
    check("abort_queue", 64'(exp_gnt_q.size()), 64'd0);

    // Misaligned CPU write to 0x013, then read back word 4
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    exp_gnt_q.push_back(gv(0, 1'b0, 1'b0, 9'h013, 32'hCAFECAFE));
    exp_q.push_back(rv(0, 1'b1, 32'h0));
`else
    exp_gnt_q.push_back(gv(0, 1'b0, 1'b1, 9'h013, 32'hCAFECAFE));
    exp_q.push_back(rv(0, 1'b0, 32'h0));
`endif
    issue(0, 1'b1, 9'h013, 32'hCAFECAFE, w0);
    settle();
    exp_gnt_q.push_back(gv(0, 1'b1, 1'b0, 9'h010, '0));
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    exp_q.push_back(rv(0, 1'b0, 32'hDEADBEEF));
`else
    exp_q.push_back(rv(0, 1'b0, 32'hCAFECAFE));
`endif
    issue(0, 1'b0, 9'h010, '0, w0);
    settle();

    check("final_gnt_queue", 64'(exp_gnt_q.size()), 64'd0);
    check("final_resp_queue", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
